// File: rtl/gcd_lcm_pkg.sv
// rtl/gcd_lcm_pkg.sv - shared state encoding, opcode constants and width helper for the GCD/LCM unit
package gcd_lcm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPT,
        GSHIFT,
        GLOOP,
        DIV,
        MUL,
        DONE
    } gcd_state_t;

    localparam logic OP_GCD = 1'b0;
    localparam logic OP_LCM = 1'b1;

    // Enough bits to count 0..width shift steps or iterations
    function automatic int shift_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_lcm_unit_seq_divmul.sv
// rtl/gcd_lcm_unit_seq_divmul.sv - sequential restoring divider and shift-add multiplier sharing one step counter
module seq_divmul
    import gcd_lcm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_div,
    input  logic             start_mul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] multiplicand,
    output logic [AW-1:0]    res,
    output logic             fin
);

    localparam int CW = shift_w(WIDTH);

    typedef enum logic [1:0] {PH_IDLE, PH_DIV, PH_MUL} phase_t;

    phase_t           phase;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] mlt;
    logic [AW-1:0]    mcand;
    logic [AW-1:0]    acc;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [AW-1:0]    acc_next;

    // One restoring-division step and one shift-add step, computed ahead so the
    // caller can capture the final value on the same edge the last step retires
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        rem_next = shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, dsr}) begin
            rem_next = shifted[WIDTH-1:0] - dsr;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
        acc_next = mlt[0] ? (acc + mcand) : acc;
        res      = (phase == PH_MUL) ? acc_next : AW'(quo_next);
        fin      = (phase != PH_IDLE) && (cnt == '0);
    end

    // Load on a start strobe, otherwise retire one bit per cycle for WIDTH cycles;
    // start_mul arrives on the last divide step, so the fresh quotient is the multiplier
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= PH_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
            mlt   <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (start_div) begin
            phase <= PH_DIV;
            cnt   <= CW'(WIDTH - 1);
            rem   <= '0;
            quo   <= dividend;
            dsr   <= divisor;
        end else if (start_mul) begin
            phase <= PH_MUL;
            cnt   <= CW'(WIDTH - 1);
            mlt   <= quo_next;
            mcand <= AW'(multiplicand);
            acc   <= '0;
        end else begin
            case (phase)
                PH_DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - 1'b1;
                    if (fin) phase <= PH_IDLE;
                end
                PH_MUL: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mlt   <= mlt >> 1;
                    cnt   <= cnt - 1'b1;
                    if (fin) phase <= PH_IDLE;
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gcd_lcm_unit.sv
// rtl/gcd_lcm_unit.sv - multi-cycle Stein GCD / LCM coprocessor; GCD_LCM_OVF_EN widens the product and enables ovf
module gcd_lcm_unit
    import gcd_lcm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int KW = shift_w(WIDTH);
`ifdef GCD_LCM_OVF_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    gcd_state_t       state;
    logic             op_r;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [KW-1:0]    k;

    logic [WIDTH-1:0] g;
    logic             start_div;
    logic             start_mul;
    logic [AW-1:0]    dm_res;
    logic             dm_fin;
    logic             ovf_next;

    // The GCD is only valid on the loop-exit cycle, where it feeds the result or the divider
    always_comb begin
        g         = ra << k;
        start_div = (state == GLOOP) && (ra == rb) && (op_r == OP_LCM);
        start_mul = (state == DIV) && dm_fin;
`ifdef GCD_LCM_OVF_EN
        ovf_next  = |dm_res[AW-1:WIDTH];
`else
        ovf_next  = 1'b0;
`endif
    end

    seq_divmul #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_divmul (
        .clk          (clk),
        .reset        (reset),
        .start_div    (start_div),
        .start_mul    (start_mul),
        .dividend     (a0),
        .divisor      (g),
        .multiplicand (b0),
        .res          (dm_res),
        .fin          (dm_fin)
    );

    // Control FSM: capture, zero screen, common-power-of-two strip, Stein loop, then divide/multiply for LCM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            op_r   <= OP_GCD;
            ra     <= '0;
            rb     <= '0;
            a0     <= '0;
            b0     <= '0;
            k      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        ra    <= src_a;
                        rb    <= src_b;
                        a0    <= src_a;
                        b0    <= src_b;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    if (ra == '0 || rb == '0) begin
                        // With one operand zero the GCD is simply the OR of both
                        result <= (op_r == OP_LCM) ? '0 : (ra | rb);
                        ovf    <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= GSHIFT;
                    end
                end
                GSHIFT: begin
                    if (!ra[0] && !rb[0]) begin
                        ra <= ra >> 1;
                        rb <= rb >> 1;
                        k  <= k + 1'b1;
                    end else begin
                        state <= GLOOP;
                    end
                end
                GLOOP: begin
                    if (ra == rb) begin
                        if (op_r == OP_GCD) begin
                            result <= g;
                            ovf    <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end else if (!ra[0]) begin
                        ra <= ra >> 1;
                    end else if (!rb[0]) begin
                        rb <= rb >> 1;
                    end else if (ra > rb) begin
                        ra <= (ra - rb) >> 1;
                    end else begin
                        rb <= (rb - ra) >> 1;
                    end
                end
                DIV: begin
                    if (dm_fin) state <= MUL;
                end
                MUL: begin
                    if (dm_fin) begin
                        result <= dm_res[WIDTH-1:0];
                        ovf    <= ovf_next;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// tb/tb_gcd_lcm_unit.sv - self-checking bench for gcd_lcm_unit against an arithmetic reference model
module tb_gcd_lcm_unit;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         reset  = 1'b0;
    logic         start  = 1'b0;
    logic         op     = 1'b0;
    logic [W-1:0] src_a  = '0;
    logic [W-1:0] src_b  = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;

    int n_pass  = 0;
    int n_total = 0;
    int n_done  = 0;

    always #5 clk = ~clk;

    gcd_lcm_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x = a;
        logic [31:0] y = b;
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [63:0] lcm_full(input logic [31:0] a, input logic [31:0] b);
        if (a == 0 || b == 0) return 64'd0;
        return 64'(a / gcd_ref(a, b)) * 64'(b);
    endfunction

    // Busy-cycle count: capture, shifts plus the exit check, loop iterations, done; LCM adds divide and multiply
    function automatic int latency(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x = a;
        logic [31:0] y = b;
        int s = 0;
        int l = 0;
        if (a == 0 || b == 0) return 2;
        while (x[0] == 1'b0 && y[0] == 1'b0) begin
            x = x / 2;
            y = y / 2;
            s++;
        end
        forever begin
            l++;
            if (x == y) break;
            else if (x[0] == 1'b0) x = x / 2;
            else if (y[0] == 1'b0) y = y / 2;
            else if (x > y) x = (x - y) / 2;
            else y = (y - x) / 2;
        end
        return 3 + s + l + (o ? 2 * W : 0);
    endfunction

    function automatic logic [31:0] exp_result(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p = lcm_full(a, b);
        return o ? p[31:0] : gcd_ref(a, b);
    endfunction

    function automatic logic exp_ovf(input logic o, input logic [31:0] a, input logic [31:0] b);
`ifdef GCD_LCM_OVF_EN
        logic [63:0] p = lcm_full(a, b);
        return o && (p[63:32] != 0);
`else
        return 1'b0 & o & a[0] & b[0];
`endif
    endfunction

    // Cycle-level model: count down busy cycles from the accept edge, pulse done in the last one
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = '0;
    logic        m_ovf  = 1'b0;
    int          m_rem  = 0;
    logic [31:0] p_res  = '0;
    logic        p_ovf  = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_ovf  <= 1'b0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) m_busy <= 1'b0;
                if (m_rem == 2) begin
                    m_done <= 1'b1;
                    m_res  <= p_res;
                    m_ovf  <= p_ovf;
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_rem  <= latency(op, src_a, src_b);
                p_res  <= exp_result(op, src_a, src_b);
                p_ovf  <= exp_ovf(op, src_a, src_b);
            end
        end
    end

    // Compare every output on every cycle, away from the active edge
    always @(negedge clk) begin
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("result", result, m_res);
        check("ovf", ovf, m_ovf);
        if (done === 1'b1) n_done++;
    end

    task automatic wait_idle();
        int c = 0;
        while (m_busy && c < 400) begin
            @(negedge clk);
            c++;
        end
        n_total++;
        if (m_busy) $display("FAIL wait_idle: got busy after %0d cycles expected idle", c);
        else n_pass++;
    endtask

    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;

        check("pin_gcd_48_18", 64'(gcd_ref(32'd48, 32'd18)), 64'd6);
        check("pin_lcm_4_6", lcm_full(32'd4, 32'd6), 64'd12);
        check("pin_lcm_21_6", lcm_full(32'd21, 32'd6), 64'd42);
        check("pin_lcm_big", lcm_full(32'hFFFF_FFFF, 32'hFFFF_FFFE), 64'hFFFF_FFFD_0000_0002);
        check("pin_lat_gcd_48_18", 64'(latency(1'b0, 32'd48, 32'd18)), 64'd9);
        check("pin_lat_lcm_4_6", 64'(latency(1'b1, 32'd4, 32'd6)), 64'd71);
        check("pin_lat_zero", 64'(latency(1'b0, 32'd0, 32'd7)), 64'd2);

        do_op(1'b0, 32'd48, 32'd18);
        check("gcd_48_18", 64'(result), 64'd6);
        do_op(1'b0, 32'd18, 32'd48);
        check("gcd_18_48", 64'(result), 64'd6);
        do_op(1'b1, 32'd4, 32'd6);
        check("lcm_4_6", 64'(result), 64'd12);
        do_op(1'b1, 32'd21, 32'd6);
        check("lcm_21_6", 64'(result), 64'd42);
        do_op(1'b0, 32'd0, 32'd7);
        check("gcd_0_7", 64'(result), 64'd7);
        do_op(1'b0, 32'd0, 32'd0);
        check("gcd_0_0", 64'(result), 64'd0);
        do_op(1'b1, 32'd0, 32'd5);
        check("lcm_0_5", 64'(result), 64'd0);
        do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        check("lcm_big_result", 64'(result), 64'd2);
`ifdef GCD_LCM_OVF_EN
        check("lcm_big_ovf", 64'(ovf), 64'd1);
`else
        check("lcm_big_ovf", 64'(ovf), 64'd0);
`endif

        // Second start while busy must be ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; src_a = 32'd48; src_b = 32'd18;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 1'b1; src_a = 32'd100; src_b = 32'd75;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("ignored_start", 64'(result), 64'd6);

        // Abort an LCM during its divide phase
        @(negedge clk);
        start = 1'b1; op = 1'b1; src_a = 32'd12; src_b = 32'd18;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        #2 reset = 1'b1;
        do_op(1'b0, 32'd12, 32'd18);
        check("gcd_12_18", 64'(result), 64'd6);

        // start held high across an operation is re-accepted only in the idle cycle after done
        @(negedge clk);
        start = 1'b1; op = 1'b0; src_a = 32'd21; src_b = 32'd6;
        @(negedge clk);
        wait_idle();
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("gcd_hold", 64'(result), 64'd3);

        do_op(1'b0, 32'h8000_0000, 32'h8000_0000);
        check("gcd_pow2", 64'(result), 64'h8000_0000);
        do_op(1'b1, 32'h8000_0000, 32'd2);
        check("lcm_pow2", 64'(result), 64'h8000_0000);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1);
        check("gcd_max_1", 64'(result), 64'd1);

        @(negedge clk);
        check("done_count", 64'(n_done), 64'd15);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
